// File: rtl/parking_input_frontend.sv
// ---------------------------------------------------------------------------
// parking_input_frontend
//
// Input front end of the parking controller. It cleans up the two car sensors
// and captures a two-digit keypad password.
//
//   * Each raw sensor goes through a 2-flop synchronizer and then a debouncer.
//     A debounced output changes only after the synchronized value has
//     differed from it for DEBOUNCE_CYCLES consecutive cycles. The latency
//     from a clean raw edge to the output edge is 2 + DEBOUNCE_CYCLES.
//   * The keypad FSM steps EMPTY -> ONE_DIGIT -> FULL. The stored digits are
//     shown on the outputs only in FULL, so a partial entry is never visible.
//     A debounced exit-sensor rise in FULL consumes the entry. key_clear wins
//     over every other event in the same cycle.
//
// Optional feature (macro PARK_KEY_TIMEOUT_EN):
//   When the macro is defined, the block gives up in ONE_DIGIT after
//   TIMEOUT_CYCLES cycles with no second key. It returns to EMPTY and pulses
//   entry_timeout for one cycle. When the macro is undefined, there is no
//   timeout counter, entry_timeout is tied low, and ONE_DIGIT waits forever.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a sensor output changes (1..65535)
//   TIMEOUT_CYCLES   cycles allowed between first and second digit (2..65535)
//
// Ports:
//   clk              clock; all state changes on its rising edge
//   reset_n          asynchronous active-low reset
//   raw_entrance     raw, bouncing entrance sensor (asynchronous)
//   raw_exit         raw, bouncing exit sensor (asynchronous)
//   key_valid        one-cycle keypad strobe
//   key_code[1:0]    digit value, sampled when key_valid=1
//   key_clear        one-cycle clear request
//   sensor_entrance  debounced entrance sensor
//   sensor_exit      debounced exit sensor
//   password_1[1:0]  first digit (2'b00 unless FULL)
//   password_2[1:0]  second digit (2'b00 unless FULL)
//   pass_ready       registered; high exactly while in FULL
//   entry_timeout    one-cycle pulse when digit entry times out
// ---------------------------------------------------------------------------
module parking_input_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       key_valid,
    input  logic [1:0] key_code,
    input  logic       key_clear,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pass_ready,
    output logic       entry_timeout
);

    // Reject illegal parameter values at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..65535");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ONE_DIGIT = 2'd1,
        FULL      = 2'd2
    } key_state_t;

    // The output flips on the cycle the counter would reach DEBOUNCE_CYCLES.
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Sensor synchronizer + debouncer. Index 0 is the entrance, index 1 the exit.
    // -----------------------------------------------------------------------
    logic [1:0]       raw;
    logic [1:0]       sync_meta;
    logic [1:0]       sync_out;
    logic [1:0]       deb;
    logic [1:0][15:0] db_cnt;
    logic             exit_prev;
    logic             exit_rise;

    assign raw = {raw_exit, raw_entrance};

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: every stage, including both synchronizer flops, is reset. After
        // reset is released, a sensor held high must then travel the full
        // synchronizer + debounce path before its output rises.
        if (!reset_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
            deb       <= '0;
            db_cnt    <= '0;
            exit_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the synchronizer shift like a
            // real flop chain. With blocking assignments, the raw value would
            // fall through both stages in one cycle.
            sync_meta <= raw;
            sync_out  <= sync_meta;
            exit_prev <= deb[1];
            for (int i = 0; i < 2; i++) begin
                if (sync_out[i] == deb[i]) begin
                    // Agreement, or a glitch back: restart the stability count.
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_out[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign sensor_entrance = deb[0];
    assign sensor_exit     = deb[1];
    assign exit_rise       = deb[1] & ~exit_prev;

    // -----------------------------------------------------------------------
    // Keypad FSM
    // -----------------------------------------------------------------------
    key_state_t state;
    key_state_t state_nxt;
    logic [1:0] digit1;
    logic [1:0] digit2;
    logic [1:0] digit1_nxt;
    logic [1:0] digit2_nxt;

`ifdef PARK_KEY_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
    logic        timeout_fire;
`endif

    always_comb begin
        // NOTE: every variable gets a default before any branch. A path that
        // leaves one unassigned would infer a latch.
        state_nxt  = state;
        digit1_nxt = digit1;
        digit2_nxt = digit2;
`ifdef PARK_KEY_TIMEOUT_EN
        timeout_fire = 1'b0;
`endif
        if (key_clear) begin
            state_nxt  = EMPTY;
            digit1_nxt = 2'b00;
            digit2_nxt = 2'b00;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (key_valid) begin
                        digit1_nxt = key_code;
                        state_nxt  = ONE_DIGIT;
                    end
                end
                ONE_DIGIT: begin
                    // If a key arrives on the timeout cycle, the key wins.
                    if (key_valid) begin
                        digit2_nxt = key_code;
                        state_nxt  = FULL;
                    end
`ifdef PARK_KEY_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        digit1_nxt   = 2'b00;
                        state_nxt    = EMPTY;
                        timeout_fire = 1'b1;
                    end
`endif
                end
                FULL: begin
                    // Further keys are ignored. A car leaving consumes the entry.
                    if (exit_rise) begin
                        state_nxt  = EMPTY;
                        digit1_nxt = 2'b00;
                        digit2_nxt = 2'b00;
                    end
                end
                default: begin
                    state_nxt  = EMPTY;
                    digit1_nxt = 2'b00;
                    digit2_nxt = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            digit1     <= 2'b00;
            digit2     <= 2'b00;
            pass_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            digit1     <= digit1_nxt;
            digit2     <= digit2_nxt;
            pass_ready <= (state_nxt == FULL);
        end
    end

`ifdef PARK_KEY_TIMEOUT_EN
    // Counts cycles spent in ONE_DIGIT. Any state change restarts it from 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt       <= '0;
            entry_timeout <= 1'b0;
        end else begin
            entry_timeout <= timeout_fire;
            if (state != ONE_DIGIT || state_nxt != state) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end
`else
    assign entry_timeout = 1'b0;
`endif

    // Gate the digits so that a partial entry always reads as 2'b00.
    assign password_1 = (state == FULL) ? digit1 : 2'b00;
    assign password_2 = (state == FULL) ? digit2 : 2'b00;

endmodule

// File: tb/tb_parking_input_frontend.sv
// ---------------------------------------------------------------------------
// tb_parking_input_frontend
//
// Directed, self-checking bench for parking_input_frontend with
// DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=10. Expected output vectors are pushed
// to a scoreboard queue when stimulus is driven. They are popped and compared
// after the clock edge that should produce them.
// Vector layout: {sensor_entrance, sensor_exit, password_1, password_2,
//                 pass_ready, entry_timeout}
// ---------------------------------------------------------------------------
module tb_parking_input_frontend;

    localparam int unsigned DB  = 4;
    localparam int unsigned TMO = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       raw_entrance;
    logic       raw_exit;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_clear;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pass_ready;
    logic       entry_timeout;

    always #5 clk = ~clk;

    parking_input_frontend #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .raw_entrance   (raw_entrance),
        .raw_exit       (raw_exit),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_clear      (key_clear),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .password_1     (password_1),
        .password_2     (password_2),
        .pass_ready     (pass_ready),
        .entry_timeout  (entry_timeout)
    );

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       checks = 0;
    int       errors = 0;

    function automatic logic [7:0] outs_now();
        return {sensor_entrance, sensor_exit, password_1, password_2, pass_ready, entry_timeout};
    endfunction

    function automatic logic [7:0] pk(input logic ent, input logic ext,
                                      input logic [1:0] p1, input logic [1:0] p2,
                                      input logic pr, input logic to);
        return {ent, ext, p1, p2, pr, to};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] exp);
        sb_item_t item;
        item.tag = tag;
        item.exp = exp;
        sb_q.push_back(item);
    endtask

    task automatic sb_pop_check();
        sb_item_t item;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed %b expected none", outs_now());
        end else begin
            item = sb_q.pop_front();
            check(item.tag, outs_now(), item.exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        sb_push(tag, exp);
        tick();
        sb_pop_check();
    endtask

    task automatic press(input logic [1:0] code, input string tag, input logic [7:0] exp);
        key_valid = 1'b1;
        key_code  = code;
        step(tag, exp);
        key_valid = 1'b0;
        key_code  = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        raw_entrance = 1'b0;
        raw_exit     = 1'b0;
        key_valid    = 1'b0;
        key_code     = 2'b00;
        key_clear    = 1'b0;

        // Reset state
        tick();
        tick();
        sb_push("reset_state", pk(0, 0, 2'b00, 2'b00, 0, 0));
        sb_pop_check();
        reset_n = 1'b1;
        step("post_reset", pk(0, 0, 2'b00, 2'b00, 0, 0));

        // Entrance 0->1 held: output rises exactly 2+DB = 6 cycles later
        raw_entrance = 1'b1;
        for (int i = 1; i <= 5; i++) step($sformatf("ent_deb_%0d", i), pk(0, 0, 2'b00, 2'b00, 0, 0));
        step("ent_rise_6", pk(1, 0, 2'b00, 2'b00, 0, 0));

        // Exit pulsed high for 3 cycles: debounced output never moves
        raw_exit = 1'b1;
        for (int i = 1; i <= 3; i++) step($sformatf("ext_glitch_hi_%0d", i), pk(1, 0, 2'b00, 2'b00, 0, 0));
        raw_exit = 1'b0;
        for (int i = 1; i <= 6; i++) step($sformatf("ext_glitch_lo_%0d", i), pk(1, 0, 2'b00, 2'b00, 0, 0));

        // Two keys fill, third ignored, exit rise consumes
        press(2'b01, "key1_partial", pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b10, "key2_full", pk(1, 0, 2'b01, 2'b10, 1, 0));
        press(2'b11, "key3_ignored", pk(1, 0, 2'b01, 2'b10, 1, 0));
        raw_exit = 1'b1;
        for (int i = 1; i <= 5; i++) step($sformatf("exit_deb_%0d", i), pk(1, 0, 2'b01, 2'b10, 1, 0));
        tick();
        check("exit_rise_6", {7'b0, sensor_exit}, 8'd1);
        sb_push("exit_consume", pk(1, 1, 2'b00, 2'b00, 0, 0));
        for (int i = 0; i < 3 && pass_ready !== 1'b0; i++) tick();
        sb_pop_check();
        raw_exit = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        step("exit_fall", pk(1, 0, 2'b00, 2'b00, 0, 0));

        // key_clear beats key_valid in ONE_DIGIT
        press(2'b01, "clr_key1", pk(1, 0, 2'b00, 2'b00, 0, 0));
        key_clear = 1'b1;
        press(2'b11, "clear_vs_key", pk(1, 0, 2'b00, 2'b00, 0, 0));
        key_clear = 1'b0;
        press(2'b10, "clr_after_k1", pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b11, "clr_after_full", pk(1, 0, 2'b10, 2'b11, 1, 0));
        key_clear = 1'b1;
        step("clear_full", pk(1, 0, 2'b00, 2'b00, 0, 0));
        key_clear = 1'b0;

        // Digit-entry timeout
        press(2'b01, "t_key1", pk(1, 0, 2'b00, 2'b00, 0, 0));
        for (int i = 1; i <= 9; i++) step($sformatf("t_wait_%0d", i), pk(1, 0, 2'b00, 2'b00, 0, 0));
`ifdef PARK_KEY_TIMEOUT_EN
        step("t_pulse", pk(1, 0, 2'b00, 2'b00, 0, 1));
        step("t_pulse_end", pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b10, "t_back_empty", pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b11, "t_refill", pk(1, 0, 2'b10, 2'b11, 1, 0));
`else
        step("t_no_pulse", pk(1, 0, 2'b00, 2'b00, 0, 0));
        step("t_no_pulse_2", pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b10, "t_still_one_digit", pk(1, 0, 2'b01, 2'b10, 1, 0));
`endif
        key_clear = 1'b1;
        step("t_clear", pk(1, 0, 2'b00, 2'b00, 0, 0));
        key_clear = 1'b0;

        // A key on the timeout cycle wins
        press(2'b01, "tc_key1", pk(1, 0, 2'b00, 2'b00, 0, 0));
        for (int i = 1; i <= 9; i++) step($sformatf("tc_wait_%0d", i), pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b11, "tc_key_wins", pk(1, 0, 2'b01, 2'b11, 1, 0));
        step("tc_no_pulse", pk(1, 0, 2'b01, 2'b11, 1, 0));
        key_clear = 1'b1;
        step("tc_clear", pk(1, 0, 2'b00, 2'b00, 0, 0));
        key_clear = 1'b0;

        // Asynchronous reset while FULL and mid-debounce
        press(2'b10, "r_key1", pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b01, "r_full", pk(1, 0, 2'b10, 2'b01, 1, 0));
        raw_entrance = 1'b0;
        for (int i = 1; i <= 3; i++) step($sformatf("r_mid_deb_%0d", i), pk(1, 0, 2'b10, 2'b01, 1, 0));
        #2;
        reset_n = 1'b0;
        #1;
        sb_push("async_reset", pk(0, 0, 2'b00, 2'b00, 0, 0));
        sb_pop_check();
        raw_entrance = 1'b1;
        tick();
        step("reset_held", pk(0, 0, 2'b00, 2'b00, 0, 0));
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) step($sformatf("rel_deb_%0d", i), pk(0, 0, 2'b00, 2'b00, 0, 0));
        step("rel_rise_6", pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b11, "rel_key1", pk(1, 0, 2'b00, 2'b00, 0, 0));
        press(2'b10, "rel_full", pk(1, 0, 2'b11, 2'b10, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
